// File: rtl/decoder_rr_arbiter_if.sv
// Request/grant bundle between the requesting logic and the decoder arbiter.
// master = requester side, slave = arbiter side.
interface decoder_rr_arbiter_if;
    logic [15:0] req;
    logic        done;
    logic [3:0]  sel;
    logic        gnt_valid;
    logic [15:0] gnt;
    logic        timeout;

    modport master (
        output req,
        output done,
        input  sel,
        input  gnt_valid,
        input  gnt,
        input  timeout
    );

    modport slave (
        input  req,
        input  done,
        output sel,
        output gnt_valid,
        output gnt,
        output timeout
    );
endinterface

// File: rtl/decoder_rr_arbiter.sv
// Round-robin arbiter driving the select lines of a shared 4-to-16 decoder, with one dead
// cycle between grants. Define DEC_ARB_TIMEOUT_EN to enable the MAX_HOLD forced release.
module decoder_rr_arbiter #(
    parameter int unsigned MAX_HOLD = 8
) (
    input logic                 clk,
    input logic                 rst,
    decoder_rr_arbiter_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StGrant, StGap} state_e;

    state_e     state_q, state_d;
    logic [3:0] sel_q, sel_d;
    logic [3:0] ptr_q, ptr_d;
    logic       gnt_valid_q, gnt_valid_d;
    logic       timeout_q, timeout_d;

    logic       win_found;
    logic [3:0] win_idx;
    logic [3:0] scan_idx;
    logic       normal_rel;
    logic       forced_rel;

    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("decoder_rr_arbiter: MAX_HOLD must be in 2..255");
    end

`ifdef DEC_ARB_TIMEOUT_EN
    logic [7:0] hold_cnt_q, hold_cnt_d;
`endif

    // Rotating priority scan starting at ptr_q; first hit wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = 4'd0;
        scan_idx  = 4'd0;
        for (int k = 0; k < 16; k++) begin
            scan_idx = ptr_q + 4'(k);
            if (!win_found && bus.req[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = scan_idx;
            end
        end
    end

    assign normal_rel = !bus.req[sel_q] || bus.done;

`ifdef DEC_ARB_TIMEOUT_EN
    assign forced_rel = (hold_cnt_q == 8'(MAX_HOLD - 1)) && !normal_rel;
`else
    assign forced_rel = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        ptr_d       = ptr_q;
        gnt_valid_d = gnt_valid_q;
        timeout_d   = 1'b0;
`ifdef DEC_ARB_TIMEOUT_EN
        hold_cnt_d  = hold_cnt_q;
`endif
        unique case (state_q)
            StIdle, StGap: begin
                if (win_found) begin
                    state_d     = StGrant;
                    sel_d       = win_idx;
                    gnt_valid_d = 1'b1;
`ifdef DEC_ARB_TIMEOUT_EN
                    hold_cnt_d  = 8'd0;
`endif
                end else begin
                    state_d     = StIdle;
                    gnt_valid_d = 1'b0;
                end
            end
            StGrant: begin
                if (normal_rel || forced_rel) begin
                    // sel is held through GAP so the decoder lines never glitch
                    state_d     = StGap;
                    gnt_valid_d = 1'b0;
                    ptr_d       = sel_q + 4'd1;
                    timeout_d   = forced_rel;
                end else begin
`ifdef DEC_ARB_TIMEOUT_EN
                    hold_cnt_d = hold_cnt_q + 8'd1;
`endif
                end
            end
            default: begin
                state_d     = StIdle;
                gnt_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            sel_q       <= 4'd0;
            ptr_q       <= 4'd0;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            ptr_q       <= ptr_d;
            gnt_valid_q <= gnt_valid_d;
            timeout_q   <= timeout_d;
        end
    end

`ifdef DEC_ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt_q <= 8'd0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
        end
    end
`endif

    assign bus.sel       = sel_q;
    assign bus.gnt_valid = gnt_valid_q;
    assign bus.gnt       = gnt_valid_q ? (16'h0001 << sel_q) : 16'h0000;
`ifdef DEC_ARB_TIMEOUT_EN
    assign bus.timeout   = timeout_q;
`else
    assign bus.timeout   = 1'b0;
`endif

`ifndef DEC_ARB_TIMEOUT_EN
    // timeout_q is always 0 here; fold it into a sink so it stays referenced
    logic unused_timeout;
    assign unused_timeout = timeout_q;
`endif

endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// Directed bench for decoder_rr_arbiter: expected grant indices are queued when requests are
// driven and popped as grants appear; a monitor guards against back-to-back different grants.
module tb_decoder_rr_arbiter;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    logic [3:0] exp_q[$];
    logic       prev_gv;
    logic [3:0] prev_sel;

    decoder_rr_arbiter_if bus ();

    decoder_rr_arbiter #(
        .MAX_HOLD (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pop_check(input string tag);
        logic [3:0]  e;
        logic [15:0] one;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s: grant seen with empty scoreboard, observed sel %h", tag, bus.sel);
        end else begin
            e   = exp_q.pop_front();
            one = 16'h0001 << e;
            chk({tag, "_sel"}, 32'(bus.sel), 32'(e));
            chk({tag, "_gnt"}, 32'(bus.gnt), 32'(one));
        end
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        bus.req  = 16'h0000;
        bus.done = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    // Each grant: check, hold one cycle, pulse done, check the dead cycle, advance.
    task automatic done_grants(input string tag, input int n);
        logic [3:0] held;
        step();
        for (int i = 0; i < n; i++) begin
            chk({tag, "_valid"}, 32'(bus.gnt_valid), 32'd1);
            held = bus.sel;
            pop_check(tag);
            step();
            chk({tag, "_hold"}, {27'd0, bus.gnt_valid, bus.sel}, {27'd0, 1'b1, held});
            bus.done = 1'b1;
            step();
            bus.done = 1'b0;
            chk({tag, "_gap"}, {27'd0, bus.gnt_valid, bus.sel}, {27'd0, 1'b0, held});
            chk({tag, "_gap_gnt"}, 32'(bus.gnt), 32'd0);
            if (i == n - 1) bus.req = 16'h0000;
            step();
        end
        chk({tag, "_end_idle"}, 32'(bus.gnt_valid), 32'd0);
    endtask

    // No two adjacent valid cycles may carry different selects.
    always @(negedge clk) begin
        if (!rst && prev_gv && bus.gnt_valid) begin
            checks++;
            assert (bus.sel === prev_sel) else begin
                errors++;
                $error("FAIL b2b_sel: observed %h expected %h", bus.sel, prev_sel);
            end
        end
        prev_gv  <= bus.gnt_valid;
        prev_sel <= bus.sel;
    end

    initial begin
        checks   = 0;
        errors   = 0;
        prev_gv  = 1'b0;
        prev_sel = 4'd0;

        // 1: reset, then idle with no requests
        do_reset();
        for (int i = 0; i < 10; i++) begin
            chk("idle", {10'd0, bus.gnt_valid, bus.sel, bus.gnt, bus.timeout}, 32'd0);
            step();
        end

        // 2: single requester, one-cycle latency, release by dropping req
        bus.req = 16'h0001;
        exp_q.push_back(4'd0);
        step();
        chk("single_latency", 32'(bus.gnt_valid), 32'd1);
        pop_check("single");
        bus.req = 16'h0000;
        step();
        chk("single_drop", {27'd0, bus.gnt_valid, bus.sel}, 32'd0);
        step();
        chk("single_gap", 32'(bus.gnt_valid), 32'd0);
        step();
        chk("single_idle", {16'd0, bus.gnt}, 32'd0);

        // 3: all requesting, full rotation with wrap
        do_reset();
        bus.req = 16'hFFFF;
        for (int i = 0; i < 16; i++) exp_q.push_back(4'(i));
        exp_q.push_back(4'd0);
        done_grants("rot", 17);

        // 4: two far-apart requesters alternate
        do_reset();
        bus.req = 16'h8001;
        exp_q.push_back(4'd0);
        exp_q.push_back(4'd15);
        exp_q.push_back(4'd0);
        exp_q.push_back(4'd15);
        done_grants("alt", 4);

`ifdef DEC_ARB_TIMEOUT_EN
        // 5: forced release after 8 grant cycles
        do_reset();
        bus.req = 16'h0004;
        for (int i = 0; i < 3; i++) exp_q.push_back(4'd2);
        step();
        for (int rep = 0; rep < 2; rep++) begin
            chk("to_valid", 32'(bus.gnt_valid), 32'd1);
            pop_check("to");
            repeat (7) begin
                step();
                chk("to_hold", {30'd0, bus.gnt_valid, bus.timeout}, 32'd2);
            end
            step();
            chk("to_fall", {30'd0, bus.gnt_valid, bus.timeout}, 32'd1);
            step();
            chk("to_regrant", {30'd0, bus.gnt_valid, bus.timeout}, 32'd2);
        end
        pop_check("to_third");
        bus.req = 16'h0000;
        step();
        chk("to_normal_rel", {30'd0, bus.gnt_valid, bus.timeout}, 32'd0);
`else
        // 5 (feature off): holder keeps the grant indefinitely, timeout stays low
        do_reset();
        bus.req = 16'h0004;
        exp_q.push_back(4'd2);
        step();
        pop_check("hold");
        for (int i = 0; i < 20; i++) begin
            step();
            chk("hold_forever", {26'd0, bus.gnt_valid, bus.timeout, bus.sel}, 32'h22);
        end
        bus.req = 16'h0000;
        step();
        chk("hold_release", 32'(bus.gnt_valid), 32'd0);
`endif

        // 6: reset mid-grant clears sel and ptr (ptr would otherwise be 6)
        do_reset();
        bus.req = 16'h0020;
        exp_q.push_back(4'd5);
        exp_q.push_back(4'd5);
        step();
        pop_check("rst_first");
        bus.done = 1'b1;
        step();
        bus.done = 1'b0;
        step();
        chk("rst_regrant", 32'(bus.gnt_valid), 32'd1);
        pop_check("rst_regrant");
        rst     = 1'b1;
        bus.req = 16'h0060;
        step();
        chk("rst_mid", {11'd0, bus.gnt_valid, bus.sel, bus.gnt}, 32'd0);
        rst = 1'b0;
        exp_q.push_back(4'd5);
        step();
        chk("rst_after_valid", 32'(bus.gnt_valid), 32'd1);
        pop_check("rst_after");
        bus.req = 16'h0000;
        step();
        step();

        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
